// File: rtl/tristate_buffer.sv
// tristate_buffer: enable-gated bus driver with registered last-value and drive-state capture
module tristate_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] in,
   output wire  [WIDTH-1:0] out,
   output logic [WIDTH-1:0] last,
   output logic             active
);
   logic drive;
   assign drive = en & rst_n;
   assign out = drive ? in : {WIDTH{1'bz}};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         last   <= '0;
         active <= 1'b0;
      end else begin
         if (drive) last <= in;
         active <= drive;
      end
endmodule

// File: tb/tb_tristate_buffer.sv
// tb_tristate_buffer: table-driven and hand-sequenced checks of bus drive, release and capture registers
module tb_tristate_buffer;
   localparam int W = 8;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic [W-1:0] din = '0;
   wire  [W-1:0] out_w;
   logic [W-1:0] last;
   logic         active;
   int checks = 0;
   int fails = 0;

   tristate_buffer #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .in(din),
      .out(out_w), .last(last), .active(active)
   );

   always #5 clk = ~clk;

   wire is_z = (out_w === {W{1'bz}});

   typedef struct {
      logic         en;
      logic [W-1:0] din;
      logic [W-1:0] exp_last;
      logic         exp_active;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // out is expected to carry din when drv=1, and to be fully released otherwise
   task automatic chk_out(input string name, input logic drv, input logic [W-1:0] exp);
      checks++;
      if (drv ? (out_w !== exp) : !is_z) begin
         fails++;
         $display("FAIL %s: got %h expected %s", name, out_w, drv ? $sformatf("%h", exp) : "zz");
      end
   endtask

   initial begin
      vecs[0] = '{1'b0, 8'h00, 8'h00, 1'b0};
      vecs[1] = '{1'b1, 8'hAA, 8'hAA, 1'b1};
      vecs[2] = '{1'b0, 8'h55, 8'hAA, 1'b0};
      vecs[3] = '{1'b1, 8'h04, 8'h04, 1'b1};
      vecs[4] = '{1'b1, 8'hFF, 8'hFF, 1'b1};
      vecs[5] = '{1'b0, 8'h00, 8'hFF, 1'b0};
      vecs[6] = '{1'b1, 8'h00, 8'h00, 1'b1};

      // reset held across clock edges with en=1: bus released, registers cleared
      en = 1'b1; din = 8'h3C;
      repeat (2) @(posedge clk);
      #1;
      chk_out("rst_out", 1'b0, '0);
      chk("rst_last", last, 8'h00);
      chk("rst_active", {7'b0, active}, 8'h00);

      @(negedge clk);
      en = 1'b0; din = 8'h00;
      #2 rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         en = vecs[i].en; din = vecs[i].din;
         #1 chk_out($sformatf("vec%0d_out", i), vecs[i].en, vecs[i].din);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_last", i), last, vecs[i].exp_last);
         chk($sformatf("vec%0d_active", i), {7'b0, active}, {7'b0, vecs[i].exp_active});
      end

      // in changes while driving follow immediately; while released they are ignored
      @(negedge clk);
      en = 1'b1; din = 8'h11;
      #1 chk_out("follow_a", 1'b1, 8'h11);
      din = 8'hE7;
      #1 chk_out("follow_b", 1'b1, 8'hE7);
      en = 1'b0;
      #1 chk_out("release", 1'b0, '0);
      din = 8'h99;
      #1 chk_out("ignore_in", 1'b0, '0);

      // en rising switches bus from Z to data in the same step
      @(negedge clk);
      en = 1'b0; din = 8'hFF;
      #1 chk_out("en_low", 1'b0, '0);
      en = 1'b1;
      #1 chk_out("en_rise", 1'b1, 8'hFF);

      // async reset pulse between edges while driving
      @(negedge clk);
      din = 8'h3C;
      @(posedge clk);
      #1 chk("pre_pulse_last", last, 8'h3C);
      @(negedge clk);
      din = 8'h5A;
      #1 rst_n = 1'b0;
      #1;
      chk_out("pulse_out", 1'b0, '0);
      chk("pulse_last", last, 8'h00);
      chk("pulse_active", {7'b0, active}, 8'h00);
      din = 8'h3C;
      rst_n = 1'b1;
      #1;
      chk_out("release_out", 1'b1, 8'h3C);
      chk("release_last", last, 8'h00);
      chk("release_active", {7'b0, active}, 8'h00);
      @(posedge clk);
      #1;
      chk("post_edge_last", last, 8'h3C);
      chk("post_edge_active", {7'b0, active}, 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/tristate_buffer.md
TRISTATE_BUFFER -- requirements
Module: tristate_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data path width in bits (legal range 1..64).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk  input  1  SHALL be the single clock; all registers update on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port en  input  1  SHALL be the output enable; 1 = drive, 0 = release the bus.
REQ-006 Port in  input  WIDTH  SHALL be the data to place on the bus.
REQ-007 Port out  output  WIDTH  SHALL be the tri-state bus output.
REQ-008 Port last  output  WIDTH  SHALL be a registered copy of the last value driven onto out.
REQ-009 Port active  output  1  SHALL be a registered copy of the effective drive state.

Function
REQ-010 With rst_n=1 and en=1, out SHALL equal in combinationally; no clock latency.
REQ-011 With en=0, every bit of out SHALL be high-impedance (Z).
REQ-012 With rst_n=0, out SHALL be all-Z regardless of en and in.
REQ-013 The effective drive state SHALL be defined as drive = en AND rst_n.
REQ-014 A change on in while drive=1 SHALL appear on out in the same delta/timestep.
REQ-015 A change on in while drive=0 SHALL have no effect on out.
REQ-016 A change on en SHALL switch out between in and Z in the same timestep.
REQ-017 On each rising clk edge with drive=1, last SHALL load in.
REQ-018 On each rising clk edge with drive=0, last SHALL hold its value.
REQ-019 On each rising clk edge, active SHALL load drive.
REQ-020 Every bit of out SHALL be driven from the same enable; partial-width drive is not permitted.
REQ-021 X on en SHALL produce X on out, with no silent choice between driving and Z.
REQ-022 last and active SHALL never be Z; both are driven from registers at all times.

Reset
REQ-023 Asserting rst_n low SHALL immediately set last to 0, set active to 0 and put out to all-Z, with no clock required.
REQ-024 Deasserting rst_n SHALL restore combinational drive of out per en at once.
REQ-025 After rst_n is deasserted, last and active SHALL first update on the next rising clk edge.
REQ-026 Reset asserted while drive=1 SHALL release the bus in the same timestep.

Verification
REQ-027 Scenario: rst_n=1, en=0, in=8'h00 -> out=ZZ, last=8'h00, active=0.
REQ-028 Scenario: en=1, then in=8'hAA -> out=8'hAA in the same timestep; after the next clk edge last=8'hAA and active=1.
REQ-029 Scenario: en=0, then in=8'h55 -> out=ZZ; last holds 8'hAA; active=0 after the next clk edge.
REQ-030 Scenario: en=1, in=8'h04 -> out=8'h04 immediately; last=8'h04 after a clk edge.
REQ-031 Scenario: en=0, in=8'hFF, then en=1 -> out goes from ZZ to 8'hFF at the instant en rises.
REQ-032 Scenario: en=1, in=8'h3C, rst_n pulsed low between clk edges -> out=ZZ, last=0, active=0 during the pulse; out=8'h3C immediately after release; last=8'h3C after the next edge.
